ram8_bank: RTL and testbench
============================

// Module: ram8_bank
// PURPOSE
//  Eight-entry register bank; the stage directly downstream of DMUX8Way.
//  Consumes the demux's eight one-hot outputs as per-entry write enables
//  (demux X = load, s = write address) and stores the shared data word.
//  Provides a registered read port with one-cycle latency.
//  Raises a sticky error flag on a malformed (non-one-hot) enable vector.
// PARAMETERS
//  WIDTH      16      data word width in bits
//  RESET_VAL  0       value loaded into every entry on reset (WIDTH bits)
// PORTS
//  clk        in   1      single clock, rising edge
//  rst_n      in   1      asynchronous, active-low reset
//  we         in   8      enables from DMUX8Way; we[i] = OUT(i+1)
//  din        in   WIDTH  write data, shared by all entries
//  rd_en      in   1      read request
//  rd_addr    in   3      read entry index 0..7
//  dout       out  WIDTH  read data, registered
//  dout_valid out  1      dout holds the result of last cycle's rd_en
//  written    out  8      bit i set once entry i has been written since reset
//  err        out  1      sticky: a multi-hot we vector was seen
//  err_clr    in   1      clears err
// BEHAVIOUR
//  Reset (rst_n=0, async, takes effect immediately without a clock edge):
//  - All entries = RESET_VAL; dout=0, dout_valid=0, written=0, err=0.
//  - A read in flight is dropped: dout_valid is 0 on the first edge after release.
//  Write, evaluated at each rising edge:
//  - we==0: no write.
//  - popcount(we)==1, we[i]=1: entry i <= din; written[i] <= 1.
//  - popcount(we)>=2: no entry changes; written unchanged; err <= 1.
//  Read, one-cycle latency:
//  - rd_en=1 at edge N: dout = entry[rd_addr] and dout_valid=1 after edge N.
//  - rd_en=0 at edge N: dout_valid=0 after edge N; dout holds its previous value.
//  - An unwritten entry reads as RESET_VAL; dout_valid is still 1.
//  - Read and valid write to the same entry at the same edge: write-first,
//    so dout = din. Read of a different entry at that edge returns the old contents.
//  - Multi-hot we plus a read at the same edge: read returns the
//    unmodified entry.
//  - Back-to-back rd_en: one result per cycle, no bubbles.
//  Error flag:
//  - err_clr=1 at an edge clears err, unless a multi-hot we occurs at
//    the same edge; then err stays 1 (set wins).
//  - err does not block later valid writes.
//  - Arithmetic: none beyond the popcount; no wrap; rd_addr covers all 8 entries.
//  Timing: all outputs change only on clk or rst_n; no combinational path
//  from input to output.
// TESTING
//  1 Reset with RESET_VAL=16'hA5A5, then rd_en with rd_addr 0..7 ->
//    dout=A5A5, dout_valid=1 one cycle after each request, written=8'h00.
//  2 Drive we=1<<i with din=16'h1000+i for i=0..7, then read all
//    entries -> dout=1000+i, written=8'hFF, err=0.
//  3 we=8'h04, din=16'hBEEF, rd_en=1, rd_addr=2 at the same edge ->
//    next cycle dout=BEEF (write-first); rd_addr=3 at that edge -> old entry 3.
//  4 we=8'h11, din=16'hDEAD -> entries 0 and 4 unchanged, err=1;
//    err_clr plus we=8'h03 at the same edge -> err stays 1;
//    err_clr alone -> err=0.
//  5 rd_en=1 at an edge, then rst_n=0 mid-cycle -> dout=0 and
//    dout_valid=0 immediately; after release, written=0 and all entries
//    read RESET_VAL.
//  6 rd_en held high for 8 cycles sweeping rd_addr -> eight consecutive
//    valid outputs; drop rd_en -> dout_valid=0 and dout holds its last value.

Source files
------------

// File: rtl/ram8_bank.sv
// Eight-entry register bank fed by one-hot write enables from an 8-way demux.
// Registered read port with write-first bypass and a sticky multi-hot error flag.
module ram8_bank #(
   parameter int unsigned       WIDTH     = 16,
   parameter logic [WIDTH-1:0]  RESET_VAL = '0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [7:0]       we,
   input  logic [WIDTH-1:0] din,
   input  logic             rd_en,
   input  logic [2:0]       rd_addr,
   output logic [WIDTH-1:0] dout,
   output logic             dout_valid,
   output logic [7:0]       written,
   output logic             err,
   input  logic             err_clr
);

   logic [WIDTH-1:0] mem_q [8];
   logic [WIDTH-1:0] dout_q, dout_d;
   logic             valid_q;
   logic [7:0]       written_q, written_d;
   logic             err_q, err_d;
   logic             we_any, we_onehot, we_multi;
   logic [WIDTH-1:0] rd_data;

   // Clearing the lowest set bit leaves zero only for a single-bit vector.
   always_comb begin
      we_any    = (we != 8'd0);
      we_onehot = we_any && ((we & (we - 8'd1)) == 8'd0);
      we_multi  = we_any && !we_onehot;
   end

   // Write-first: a valid write to the entry being read bypasses to the read port.
   always_comb begin
      rd_data = mem_q[rd_addr];
      if (we_onehot && we[rd_addr]) begin
         rd_data = din;
      end
   end

   always_comb begin
      dout_d    = dout_q;
      written_d = written_q;
      err_d     = err_q;
      if (rd_en) begin
         dout_d = rd_data;
      end
      if (we_onehot) begin
         written_d = written_q | we;
      end
      if (we_multi) begin
         err_d = 1'b1;
      end else if (err_clr) begin
         err_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 8; i++) begin
            mem_q[i] <= RESET_VAL;
         end
      end else if (we_onehot) begin
         for (int i = 0; i < 8; i++) begin
            if (we[i]) begin
               mem_q[i] <= din;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dout_q    <= '0;
         valid_q   <= 1'b0;
         written_q <= 8'd0;
         err_q     <= 1'b0;
      end else begin
         dout_q    <= dout_d;
         valid_q   <= rd_en;
         written_q <= written_d;
         err_q     <= err_d;
      end
   end

   assign dout       = dout_q;
   assign dout_valid = valid_q;
   assign written    = written_q;
   assign err        = err_q;

endmodule

// File: tb/tb_ram8_bank.sv
// Directed self-checking bench for ram8_bank with RESET_VAL = 16'hA5A5.
module tb_ram8_bank;

   localparam int unsigned      WIDTH = 16;
   localparam logic [WIDTH-1:0] RV    = 16'hA5A5;

   logic             clk;
   logic             rst_n;
   logic [7:0]       we;
   logic [WIDTH-1:0] din;
   logic             rd_en;
   logic [2:0]       rd_addr;
   logic [WIDTH-1:0] dout;
   logic             dout_valid;
   logic [7:0]       written;
   logic             err;
   logic             err_clr;

   int n_checks = 0;
   int n_fail   = 0;

   ram8_bank #(
      .WIDTH     (WIDTH),
      .RESET_VAL (RV)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .we         (we),
      .din        (din),
      .rd_en      (rd_en),
      .rd_addr    (rd_addr),
      .dout       (dout),
      .dout_valid (dout_valid),
      .written    (written),
      .err        (err),
      .err_clr    (err_clr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

   // Advance one edge; inputs and checks both happen 1 time unit after it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      we      = 8'd0;
      din     = '0;
      rd_en   = 1'b0;
      rd_addr = 3'd0;
      err_clr = 1'b0;
   endtask

   task automatic test_reset();
      idle();
      rst_n = 1'b0;
      repeat (3) tick();
      rst_n = 1'b1;
      tick();
      n_checks++;
      if (dout !== 16'h0000 || dout_valid !== 1'b0 || written !== 8'h00 || err !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_state: dout=%h valid=%b written=%h err=%b, required 0000 0 00 0",
                  dout, dout_valid, written, err);
      end
      for (int a = 0; a < 8; a++) begin
         rd_en   = 1'b1;
         rd_addr = 3'(a);
         tick();
         n_checks++;
         if (dout !== RV || dout_valid !== 1'b1 || written !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_read[%0d]: dout=%h valid=%b written=%h, required %h 1 00",
                     a, dout, dout_valid, written, RV);
         end
      end
      idle();
      tick();
   endtask

   task automatic test_write_all();
      for (int i = 0; i < 8; i++) begin
         we  = 8'd1 << i;
         din = 16'h1000 + 16'(i);
         tick();
      end
      idle();
      for (int a = 0; a < 8; a++) begin
         rd_en   = 1'b1;
         rd_addr = 3'(a);
         tick();
         n_checks++;
         if (dout !== 16'h1000 + 16'(a) || dout_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL write_read[%0d]: dout=%h valid=%b, required %h 1",
                     a, dout, dout_valid, 16'h1000 + 16'(a));
         end
      end
      idle();
      tick();
      n_checks++;
      if (written !== 8'hFF || err !== 1'b0) begin
         n_fail++;
         $display("FAIL write_flags: written=%h err=%b, required FF 0", written, err);
      end
   endtask

   task automatic test_write_first();
      we = 8'h04; din = 16'hBEEF; rd_en = 1'b1; rd_addr = 3'd2;
      tick();
      n_checks++;
      if (dout !== 16'hBEEF || dout_valid !== 1'b1) begin
         n_fail++;
         $display("FAIL write_first_same: dout=%h valid=%b, required BEEF 1", dout, dout_valid);
      end
      we = 8'h04; din = 16'hCAFE; rd_en = 1'b1; rd_addr = 3'd3;
      tick();
      n_checks++;
      if (dout !== 16'h1003) begin
         n_fail++;
         $display("FAIL write_other_entry: dout=%h, required 1003", dout);
      end
      idle();
      rd_en = 1'b1; rd_addr = 3'd2;
      tick();
      n_checks++;
      if (dout !== 16'hCAFE) begin
         n_fail++;
         $display("FAIL write_first_stored: dout=%h, required CAFE", dout);
      end
      idle();
      tick();
   endtask

   task automatic test_error();
      we = 8'h11; din = 16'hDEAD; rd_en = 1'b1; rd_addr = 3'd0;
      tick();
      n_checks++;
      if (dout !== 16'h1000 || err !== 1'b1 || written !== 8'hFF) begin
         n_fail++;
         $display("FAIL multihot_write: dout=%h err=%b written=%h, required 1000 1 FF",
                  dout, err, written);
      end
      idle();
      rd_en = 1'b1; rd_addr = 3'd4;
      tick();
      n_checks++;
      if (dout !== 16'h1004) begin
         n_fail++;
         $display("FAIL multihot_entry4: dout=%h, required 1004", dout);
      end
      idle();
      err_clr = 1'b1; we = 8'h03; din = 16'h7777;
      tick();
      n_checks++;
      if (err !== 1'b1) begin
         n_fail++;
         $display("FAIL err_set_wins: err=%b, required 1", err);
      end
      idle();
      rd_en = 1'b1; rd_addr = 3'd1;
      tick();
      n_checks++;
      if (dout !== 16'h1001) begin
         n_fail++;
         $display("FAIL multihot_entry1: dout=%h, required 1001", dout);
      end
      // Valid write while err is still set must land.
      idle();
      we = 8'h01; din = 16'h1234;
      tick();
      idle();
      rd_en = 1'b1; rd_addr = 3'd0;
      tick();
      n_checks++;
      if (dout !== 16'h1234 || err !== 1'b1) begin
         n_fail++;
         $display("FAIL write_during_err: dout=%h err=%b, required 1234 1", dout, err);
      end
      idle();
      err_clr = 1'b1;
      tick();
      n_checks++;
      if (err !== 1'b0) begin
         n_fail++;
         $display("FAIL err_clear: err=%b, required 0", err);
      end
      idle();
      tick();
   endtask

   task automatic test_async_reset();
      rd_en = 1'b1; rd_addr = 3'd5;
      tick();
      n_checks++;
      if (dout !== 16'h1005 || dout_valid !== 1'b1) begin
         n_fail++;
         $display("FAIL pre_reset_read: dout=%h valid=%b, required 1005 1", dout, dout_valid);
      end
      #2;
      rst_n = 1'b0;
      #1;
      n_checks++;
      if (dout !== 16'h0000 || dout_valid !== 1'b0 || written !== 8'h00) begin
         n_fail++;
         $display("FAIL async_reset: dout=%h valid=%b written=%h, required 0000 0 00",
                  dout, dout_valid, written);
      end
      tick();
      idle();
      rst_n = 1'b1;
      tick();
      n_checks++;
      if (dout_valid !== 1'b0 || written !== 8'h00 || err !== 1'b0) begin
         n_fail++;
         $display("FAIL post_reset_flags: valid=%b written=%h err=%b, required 0 00 0",
                  dout_valid, written, err);
      end
      for (int a = 0; a < 8; a++) begin
         rd_en   = 1'b1;
         rd_addr = 3'(a);
         tick();
         n_checks++;
         if (dout !== RV || dout_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL post_reset_read[%0d]: dout=%h valid=%b, required %h 1",
                     a, dout, dout_valid, RV);
         end
      end
      idle();
      tick();
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 8; i++) begin
         we  = 8'd1 << i;
         din = 16'h2000 + 16'(3 * i);
         tick();
      end
      idle();
      for (int a = 7; a >= 0; a--) begin
         rd_en   = 1'b1;
         rd_addr = 3'(a);
         tick();
         n_checks++;
         if (dout !== 16'h2000 + 16'(3 * a) || dout_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL burst_read[%0d]: dout=%h valid=%b, required %h 1",
                     a, dout, dout_valid, 16'h2000 + 16'(3 * a));
         end
      end
      idle();
      rd_addr = 3'd6;
      for (int k = 0; k < 2; k++) begin
         tick();
         n_checks++;
         if (dout_valid !== 1'b0 || dout !== 16'h2000) begin
            n_fail++;
            $display("FAIL burst_hold[%0d]: dout=%h valid=%b, required 2000 0",
                     k, dout, dout_valid);
         end
      end
   endtask

   initial begin
      idle();
      rst_n = 1'b0;
      test_reset();
      test_write_all();
      test_write_first();
      test_error();
      test_async_reset();
      test_back_to_back();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
